uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- Serial UART receiver with an integrated byte FIFO, sitting directly downstream of the rx pin.
- Feeds received bytes to the MCU peripheral register interface.
- Turns the 8N1 stream (e.g. from the uart_sending bench model) into buffered bytes, with sticky overrun and framing-error flags.
- The CPU drains bytes at its own pace through a pop strobe.

Parameters:
- clk_freq, 1_000_000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate.
  - Bit period DIV = clk_freq/baud_rate, integer, rounded down (104 at defaults).
  - HALF = DIV/2 (52 at defaults).
- fifo_addr_bits, 2, FIFO depth = 2**fifo_addr_bits (4 at defaults).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idle high.
- rd_en  input  1  pop strobe; one byte removed per cycle high.
- clear_err  input  1  clears overrun and frame_err.
- data_out  output  8  FIFO head byte, first-word fall-through.
- data_valid  output  1  FIFO not empty.
- count  output  fifo_addr_bits+1  number of bytes held, 0..depth.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- busy  output  1  receiver FSM not in IDLE.

Behaviour:
- **Reset** (reset=1 at a clock edge):
  - FSM to IDLE; FIFO pointers and count to 0.
  - data_valid=0, data_out=0x00, overrun=0, frame_err=0, busy=0.
  - Synchronizer flops set to 1.
  - Reset mid-frame discards the partial byte.
- **Synchronizer:** rx passes through two flops; rx_s is the second flop. All decisions use rx_s.
- **Baud counter:** reloaded on every state entry; counts down to 0.
- **FSM:**
  - IDLE: rx_s==0 -> START, counter=HALF-1.
  - START: at counter 0, sample rx_s.
    - rx_s==0 -> DATA, bit index=0, counter=DIV-1.
    - rx_s==1 -> IDLE (glitch rejected; no flag set).
  - DATA: at counter 0, shift rx_s into the shift register, LSB first, and increment the bit index.
    - After bit 7 -> STOP, counter=DIV-1.
    - Otherwise reload DIV-1.
  - STOP: at counter 0, sample rx_s.
    - rx_s==1: push byte, go to IDLE.
    - rx_s==0: no push, frame_err<=1, go to BREAK.
  - BREAK: wait until rx_s==1, then IDLE. A held-low line yields exactly one frame_err and no bytes.
- **Push latency:** the byte is visible (data_valid=1, data_out=byte, count+1) on the edge after the stop-bit sample edge.
  - At defaults, data_valid rises 2+52+8*104+104+1 = 991 cycles after the rx falling edge, ±1 for synchronizer phase.
- **FIFO:**
  - data_out always shows the head entry when data_valid=1; it holds the last popped value when empty.
  - rd_en with FIFO empty: ignored, no underflow, count stays 0.
  - Push with FIFO full and rd_en=0: byte dropped, overrun<=1, contents unchanged.
  - Push and rd_en in the same cycle:
    - Not empty: both occur, count unchanged.
    - Full: pop first, push accepted, no overrun.
    - Empty: push only; rd_en ignored.
  - Pointers wrap modulo depth; count is tracked separately, so full vs empty is unambiguous.
- **Error flags:**
  - clear_err=1 clears overrun and frame_err next edge.
  - A setting event in the same cycle as clear_err wins (flag ends 1).
  - Flags never affect FIFO contents.

Decomposition:
- No shared package needed.
- FSM state encodings (IDLE, START, DATA, STOP, BREAK) are localparams inside the module.
- DIV and HALF are localparams derived from the parameters.
- One sub-module: reflet_byte_fifo.
  - Parameter: fifo_addr_bits.
  - Ports: clk, reset, push, din[7:0], pop, dout, count, full, empty.
  - Contains the pointer/count logic and the pop-before-push rule.
- The top contains the synchronizer, baud counter, FSM, shift register and flag logic.

Test Plan:
1. Send 0xA5, 8N1 at 104 cycles/bit -> data_valid rises 991±1 cycles after the start edge; data_out=0xA5, count=1. Pulse rd_en -> count=0, data_valid=0.
2. Drive rx low for 20 cycles, then high -> busy pulses; no push, count=0, frame_err=0.
3. Send 0x3C with the stop bit driven low -> frame_err=1, count=0, FSM holds BREAK while rx is low. After rx returns high, 0x11 is received normally. clear_err -> frame_err=0.
4. Send 0x01..0x05 with no reads -> count=4, overrun=1 after the fifth stop bit. Four pops yield 01,02,03,04; a fifth pop is ignored with count=0.
5. Fill the FIFO with 0x10..0x13, then assert rd_en exactly on the push cycle of 0x14 -> overrun stays 0, count=4. Subsequent pops yield 11,12,13,14.
6. Assert reset during data bit 3 of 0x77 with bytes already held -> next edge count=0, busy=0, flags 0. Rx idling afterwards produces no byte; a following 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_buffered_byte_fifo.sv
// Byte FIFO with first-word fall-through output and a separate occupancy count.
// A pop on a full FIFO frees the slot before the same-cycle push is considered.
module reflet_byte_fifo #(
  parameter int fifo_addr_bits = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [7:0]                din,
  input  logic                      pop,
  output logic [7:0]                dout,
  output logic [fifo_addr_bits:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int DEPTH = 1 << fifo_addr_bits;
  localparam logic [fifo_addr_bits-1:0] PTR_ONE  = 1;
  localparam logic [fifo_addr_bits:0]   CNT_ONE  = 1;
  localparam logic [fifo_addr_bits:0]   CNT_FULL = CNT_ONE << fifo_addr_bits;

  logic [7:0]                r_mem [DEPTH];
  logic [fifo_addr_bits-1:0] r_wr_ptr;
  logic [fifo_addr_bits-1:0] r_rd_ptr;
  logic [fifo_addr_bits:0]   r_count;
  logic [7:0]                r_last;
  logic                      w_pop;
  logic                      w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_FULL);
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign count  = r_count;
  // When empty the output keeps showing the byte most recently popped
  assign dout   = empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky overrun and framing-error flags.
// The line is sampled mid-bit from a counter reloaded on every state entry.
module uart_rx_buffered #(
  parameter int clk_freq       = 1_000_000,
  parameter int baud_rate      = 9600,
  parameter int fifo_addr_bits = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  input  logic                    rd_en,
  input  logic                    clear_err,
  output logic [7:0]              data_out,
  output logic                    data_valid,
  output logic [fifo_addr_bits:0] count,
  output logic                    overrun,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int DIV   = clk_freq / baud_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } state_t;

  state_t           r_state;
  logic             r_rx_m;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_overrun;
  logic             r_frame_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_frame_set;
  logic             w_ovr_set;
  logic             w_cnt_zero;
  logic             w_full;
  logic             w_empty;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : (r_cnt - CNT_ONE);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = RELOAD_HALF;
        end
      end
      START: begin
        if (w_cnt_zero) begin
          if (!r_rx_s) begin
            w_state_nxt = DATA;
            w_bit_nxt   = 3'd0;
            w_cnt_nxt   = RELOAD_BIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_cnt_nxt   = RELOAD_BIT;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_cnt_zero) begin
          if (r_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low yields one frame error, then waits here for idle
        if (r_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // A full FIFO with a same-cycle pop still accepts the byte
  assign w_ovr_set = w_push & w_full & ~rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun & ~clear_err) | w_ovr_set;
      r_frame_err <= (r_frame_err & ~clear_err) | w_frame_set;
    end
  end

  reflet_byte_fifo #(
    .fifo_addr_bits(fifo_addr_bits)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_shift_nxt),
    .pop   (rd_en),
    .dout  (data_out),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign data_valid = ~w_empty;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at default parameters (104 clocks per bit).
module tb_uart_rx_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_en;
  logic       clear_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx_buffered dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_en      (rd_en),
    .clear_err  (clear_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .count      (count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ovr;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame, 1040 cycles. Strobes fire in the cycle ending at edge *_at.
  // The stop-bit level is held after the frame so a low stop leaves the line in break.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at,
                            input int clr_at, input int rst_at, output int lat);
    logic [2:0] cnt0;
    int k;
    lat = -1;
    @(posedge clk);
    #1;
    rx   = 1'b0;
    cnt0 = count;
    for (int c = 1; c <= 1040; c++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && count != cnt0) lat = c;
      if (rst_at > 0 && c == rst_at) begin
        reset = 1'b0;
        rx    = 1'b1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", data_valid, 0);
        chk("t6_rst_dout", data_out, 8'h00);
        chk("t6_rst_overrun", overrun, 0);
        chk("t6_rst_frame_err", frame_err, 0);
        return;
      end
      rd_en     = (c == pop_at - 1);
      clear_err = (c == clr_at - 1);
      reset     = (c == rst_at - 1);
      if (c % 104 == 0) begin
        k = c / 104;
        if (k <= 8) rx = d[k-1];
        else rx = stop;
      end
    end
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, data_valid, 1);
    chk({name, "_data"}, data_out, exp);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int saw_busy;

    tv[0] = '{8'h01, 1, 8'h01, 1'b0};
    tv[1] = '{8'h02, 2, 8'h01, 1'b0};
    tv[2] = '{8'h03, 3, 8'h01, 1'b0};
    tv[3] = '{8'h04, 4, 8'h01, 1'b0};
    tv[4] = '{8'h05, 4, 8'h01, 1'b1};
    tv[5] = '{8'h10, 1, 8'h10, 1'b0};
    tv[6] = '{8'h11, 2, 8'h10, 1'b0};
    tv[7] = '{8'h12, 3, 8'h10, 1'b0};
    tv[8] = '{8'h13, 4, 8'h10, 1'b0};

    reset = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_err = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("reset_count", count, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_dout", data_out, 8'h00);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);

    // Test 1: single byte and its arrival latency
    send_frame(8'hA5, 1'b1, 0, 0, 0, lat);
    checks++;
    if (lat < 990 || lat > 992) begin
      errors++;
      $display("FAIL t1_latency actual=%0d required=990..992", lat);
    end
    chk("t1_count", count, 1);
    pop_chk("t1_pop", 8'hA5);
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", data_valid, 0);

    // Test 2: short low glitch is rejected
    saw_busy = 0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) saw_busy = 1;
    end
    rx = 1'b1;
    idle(100);
    chk("t2_busy_pulsed", saw_busy, 1);
    chk("t2_busy_end", busy, 0);
    chk("t2_count", count, 0);
    chk("t2_frame_err", frame_err, 0);

    // Test 3: low stop bit, clear_err colliding with the error, break hold, recovery
    send_frame(8'h3C, 1'b0, 0, 991, 0, lat);
    idle(200);
    chk("t3_frame_err", frame_err, 1);
    chk("t3_count", count, 0);
    chk("t3_break_busy", busy, 1);
    rx = 1'b1;
    idle(10);
    chk("t3_idle_busy", busy, 0);
    chk("t3_frame_err_single", frame_err, 1);
    send_frame(8'h11, 1'b1, 0, 0, 0, lat);
    chk("t3_rx_count", count, 1);
    pop_chk("t3_pop", 8'h11);
    pulse_clear();
    chk("t3_cleared", frame_err, 0);

    // Test 4: five bytes into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      send_frame(tv[i].d, 1'b1, 0, 0, 0, lat);
      chk($sformatf("t4_count_%0d", i), count, tv[i].exp_count);
      chk($sformatf("t4_head_%0d", i), data_out, tv[i].exp_head);
      chk($sformatf("t4_ovr_%0d", i), overrun, tv[i].exp_ovr);
    end
    pop_chk("t4_pop0", 8'h01);
    pop_chk("t4_pop1", 8'h02);
    pop_chk("t4_pop2", 8'h03);
    pop_chk("t4_pop3", 8'h04);
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
    chk("t4_underflow_count", count, 0);
    chk("t4_underflow_valid", data_valid, 0);
    chk("t4_hold_last", data_out, 8'h04);
    pulse_clear();
    chk("t4_ovr_cleared", overrun, 0);

    // Test 5: pop coinciding with a push into a full FIFO
    for (int i = 5; i < 9; i++) begin
      send_frame(tv[i].d, 1'b1, 0, 0, 0, lat);
      chk($sformatf("t5_count_%0d", i), count, tv[i].exp_count);
      chk($sformatf("t5_head_%0d", i), data_out, tv[i].exp_head);
    end
    send_frame(8'h14, 1'b1, 991, 0, 0, lat);
    chk("t5_overrun", overrun, 0);
    chk("t5_count", count, 4);
    pop_chk("t5_pop0", 8'h11);
    pop_chk("t5_pop1", 8'h12);
    pop_chk("t5_pop2", 8'h13);
    pop_chk("t5_pop3", 8'h14);
    chk("t5_empty", count, 0);

    // Test 6: reset mid-frame with a byte held and a flag set
    send_frame(8'h00, 1'b0, 0, 0, 0, lat);
    rx = 1'b1;
    idle(20);
    send_frame(8'h66, 1'b1, 0, 0, 0, lat);
    chk("t6_pre_count", count, 1);
    chk("t6_pre_frame_err", frame_err, 1);
    send_frame(8'h77, 1'b1, 0, 0, 450, lat);
    idle(1200);
    chk("t6_idle_count", count, 0);
    chk("t6_idle_busy", busy, 0);
    send_frame(8'h42, 1'b1, 0, 0, 0, lat);
    chk("t6_rx_count", count, 1);
    chk("t6_rx_data", data_out, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
